// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Round-robin arbiter and sequencer that shares one external combinational
//   ALU between two requesters. A granted request has its operands registered
//   toward the ALU. One cycle later the result is captured. The result is then
//   offered on the response handshake of the granted requester until that
//   requester consumes it.
//
// Ports
//   clk, reset_n             clock, synchronous active-low reset
//   reqN_valid/ready         request handshake of requester N (ready is
//                            combinational, only in IDLE)
//   reqN_a/b/op              operands and opcode of requester N
//   rspN_valid/ready         response handshake of requester N
//   rsp_c, rsp_cout          shared response data (valid with rspN_valid)
//   alu_a/b/op               registered operands/opcode to the ALU
//   alu_c, alu_cout          ALU result and overflow flag
//   busy                     high whenever the sequencer is not IDLE
//   ops_done                 wrapping count of consumed responses
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH = 16,
    parameter int OP_W  = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OP_W-1:0]  req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OP_W-1:0]  req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_c,
    output logic             rsp_cout,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OP_W-1:0]  alu_op,
    input  logic [WIDTH-1:0] alu_c,
    input  logic             alu_cout,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [OP_W-1:0]  alu_op_q, alu_op_d;
    logic [WIDTH-1:0] rsp_c_q, rsp_c_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic [1:0]       rsp_valid_q, rsp_valid_d;  // one-hot per requester
    logic             gnt_q, gnt_d;              // ID of the request in flight
    logic             last_q, last_d;            // ID of the previous winner
    logic [CNT_W-1:0] ops_q, ops_d;
    logic             pick0_s, pick1_s;
    logic             consume_s;

    // Arbitration: on a tie the requester that did not win last time goes.
    // The two picks are mutually exclusive by construction.
    always_comb begin
        pick0_s = req0_valid & (~req1_valid | last_q);
        pick1_s = req1_valid & (~req0_valid | ~last_q);
    end

    // Next-state and handshake logic of the IDLE/ISSUE/RESP sequencer.
    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rsp_c_d     = rsp_c_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_valid_d = rsp_valid_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        ops_d       = ops_q;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        consume_s   = (rsp_valid_q[0] & rsp0_ready) | (rsp_valid_q[1] & rsp1_ready);
        case (state_q)
            S_IDLE: begin
                req0_ready = pick0_s;
                req1_ready = pick1_s;
                if (pick0_s) begin
                    alu_a_d  = req0_a;
                    alu_b_d  = req0_b;
                    alu_op_d = req0_op;
                    gnt_d    = 1'b0;
                    last_d   = 1'b0;
                    state_d  = S_ISSUE;
                end else if (pick1_s) begin
                    alu_a_d  = req1_a;
                    alu_b_d  = req1_b;
                    alu_op_d = req1_op;
                    gnt_d    = 1'b1;
                    last_d   = 1'b1;
                    state_d  = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                // The ALU has had a full cycle on the registered operands.
                rsp_c_d     = alu_c;
                rsp_cout_d  = alu_cout;
                rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (consume_s) begin
                    rsp_valid_d = 2'b00;
                    ops_d       = ops_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                rsp_valid_d = 2'b00;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            alu_a_q     <= {WIDTH{1'b0}};
            alu_b_q     <= {WIDTH{1'b0}};
            alu_op_q    <= {OP_W{1'b0}};
            rsp_c_q     <= {WIDTH{1'b0}};
            rsp_cout_q  <= 1'b0;
            rsp_valid_q <= 2'b00;
            gnt_q       <= 1'b0;
            last_q      <= 1'b1;
            ops_q       <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rsp_c_q     <= rsp_c_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_valid_q <= rsp_valid_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            ops_q       <= ops_d;
        end
    end

    // Output drive from registered state.
    always_comb begin
        alu_a      = alu_a_q;
        alu_b      = alu_b_q;
        alu_op     = alu_op_q;
        rsp_c      = rsp_c_q;
        rsp_cout   = rsp_cout_q;
        rsp0_valid = rsp_valid_q[0];
        rsp1_valid = rsp_valid_q[1];
        busy       = (state_q != S_IDLE);
        ops_done   = ops_q;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//   Directed, table-driven bench for alu_arbiter. A small behavioural ALU
//   (add with signed overflow, and, or, xor) sits behind each instance. The
//   second instance uses a 2-bit counter so that counter wrap is reachable.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [15:0] rsp_c, alu_a, alu_b, alu_c;
    logic        rsp_cout, alu_cout, busy;
    logic [3:0]  alu_op;
    logic [15:0] ops_done;

    // second instance, CNT_W = 2
    logic        w_v0, w_r0, w_r1, w_rv0, w_rv1, w_cout, w_acout, w_busy;
    logic [15:0] w_c, w_aa, w_ab, w_ac;
    logic [3:0]  w_aop;
    logic [1:0]  w_ops;

    int n_checks = 0;
    int n_errors = 0;
    int exp_ops  = 0;
    int nresp;

    always #5 clk = ~clk;

    function automatic logic [16:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] op);
        logic [15:0] r;
        logic        v;
        v = 1'b0;
        case (op)
            4'h0: begin
                r = a + b;
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            4'h2:    r = a & b;
            4'h3:    r = a | b;
            4'h6:    r = a ^ b;
            default: r = a;
        endcase
        return {v, r};
    endfunction

    assign {alu_cout, alu_c} = alu_f(alu_a, alu_b, alu_op);
    assign {w_acout, w_ac}   = alu_f(w_aa, w_ab, w_aop);

    alu_arbiter #(.WIDTH(16), .OP_W(4), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_c(rsp_c), .rsp_cout(rsp_cout),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_c(alu_c), .alu_cout(alu_cout),
        .busy(busy), .ops_done(ops_done)
    );

    alu_arbiter #(.WIDTH(16), .OP_W(4), .CNT_W(2)) dut_wrap (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(w_v0), .req0_ready(w_r0),
        .req0_a(16'h0002), .req0_b(16'h0003), .req0_op(4'h0),
        .req1_valid(1'b0), .req1_ready(w_r1),
        .req1_a(16'h0000), .req1_b(16'h0000), .req1_op(4'h0),
        .rsp0_valid(w_rv0), .rsp0_ready(1'b1),
        .rsp1_valid(w_rv1), .rsp1_ready(1'b1),
        .rsp_c(w_c), .rsp_cout(w_cout),
        .alu_a(w_aa), .alu_b(w_ab), .alu_op(w_aop),
        .alu_c(w_ac), .alu_cout(w_acout),
        .busy(w_busy), .ops_done(w_ops)
    );

    typedef struct {
        logic        v0, v1;
        logic [15:0] a0, b0;
        logic [3:0]  op0;
        logic [15:0] a1, b1;
        logic [3:0]  op1;
        logic        gnt;
        logic [15:0] c;
        logic        cout;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        // a0 b0 op0 / a1 b1 op1 -> winner, result, overflow
        vecs[0] = '{1'b1, 1'b0, 16'h0003, 16'h0004, 4'h0, 16'h0000, 16'h0000, 4'h0, 1'b0, 16'h0007, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 4'h0, 16'h7FFF, 16'h0001, 4'h0, 1'b1, 16'h8000, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 16'hF0F0, 16'hFF00, 4'h2, 16'hF0F0, 16'hFF00, 4'h6, 1'b0, 16'hF000, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 16'hF0F0, 16'hFF00, 4'h2, 16'hF0F0, 16'hFF00, 4'h6, 1'b1, 16'h0FF0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 16'hF0F0, 16'hFF00, 4'h2, 16'hF0F0, 16'hFF00, 4'h6, 1'b0, 16'hF000, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 16'hF0F0, 16'hFF00, 4'h2, 16'hF0F0, 16'hFF00, 4'h6, 1'b1, 16'h0FF0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 16'hFFFF, 16'h0001, 4'h0, 16'h0000, 16'h0000, 4'h0, 1'b0, 16'h0000, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 4'h0, 16'h8000, 16'h8000, 4'h0, 1'b1, 16'h0000, 1'b1};

        reset_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 16'h0; req0_b = 16'h0; req0_op = 4'h0;
        req1_a = 16'h0; req1_b = 16'h0; req1_op = 4'h0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        w_v0 = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;

        // reset state
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        chk("rst_alu", {alu_a, alu_b, alu_op}, 0);
        chk("rst_rsp_c", {rsp_cout, rsp_c}, 0);
        chk("rst_ops", ops_done, 0);
        chk("rst_ready", {req1_ready, req0_ready}, 0);

        // table-driven single transactions
        for (int i = 0; i < 8; i++) begin
            req0_valid = vecs[i].v0; req0_a = vecs[i].a0; req0_b = vecs[i].b0; req0_op = vecs[i].op0;
            req1_valid = vecs[i].v1; req1_a = vecs[i].a1; req1_b = vecs[i].b1; req1_op = vecs[i].op1;
            rsp0_ready = 1'b1; rsp1_ready = 1'b1;
            #1;
            chk($sformatf("v%0d_ready", i), {req1_ready, req0_ready}, vecs[i].gnt ? 2'b10 : 2'b01);
            tick();
            req0_valid = 1'b0; req1_valid = 1'b0;
            chk($sformatf("v%0d_issue_busy", i), busy, 1);
            chk($sformatf("v%0d_alu_in", i), {alu_a, alu_b, alu_op},
                vecs[i].gnt ? {vecs[i].a1, vecs[i].b1, vecs[i].op1} : {vecs[i].a0, vecs[i].b0, vecs[i].op0});
            chk($sformatf("v%0d_issue_valid", i), {rsp1_valid, rsp0_valid}, 0);
            tick();
            chk($sformatf("v%0d_rsp_valid", i), {rsp1_valid, rsp0_valid}, vecs[i].gnt ? 2'b10 : 2'b01);
            chk($sformatf("v%0d_rsp_c", i), {rsp_cout, rsp_c}, {vecs[i].cout, vecs[i].c});
            tick();
            exp_ops++;
            chk($sformatf("v%0d_ops", i), ops_done, exp_ops);
            chk($sformatf("v%0d_idle", i), {busy, rsp1_valid, rsp0_valid}, 0);
        end

        // continuous tie: grants alternate, one response every 3 cycles
        req0_valid = 1'b1; req0_a = 16'hF0F0; req0_b = 16'hFF00; req0_op = 4'h2;
        req1_valid = 1'b1; req1_a = 16'hF0F0; req1_b = 16'hFF00; req1_op = 4'h6;
        nresp = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (rsp0_valid || rsp1_valid) begin
                chk("tie_cycle", cyc, 2 + 3 * nresp);
                chk("tie_id", {rsp1_valid, rsp0_valid}, (nresp % 2) ? 2'b10 : 2'b01);
                chk("tie_c", rsp_c, (nresp % 2) ? 16'h0FF0 : 16'hF000);
                nresp++;
            end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("tie_count", nresp, 4);
        exp_ops += 4;
        chk("tie_ops", ops_done, exp_ops);

        // backpressure on requester 0 while requester 1 waits
        req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h0001; req0_op = 4'h0;
        rsp0_ready = 1'b0;
        #1;
        chk("bp_ready0", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 16'h0005; req1_b = 16'h0006; req1_op = 4'h0;
        #1;
        chk("bp_issue_ready1", req1_ready, 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold_valid", {rsp1_valid, rsp0_valid}, 2'b01);
            chk("bp_hold_c", rsp_c, 16'h1235);
            chk("bp_hold_ready1", req1_ready, 0);
            tick();
        end
        rsp0_ready = 1'b1;
        tick();
        chk("bp_release_idle", {busy, rsp0_valid}, 0);
        chk("bp_release_ready1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        chk("bp_r1_issue", busy, 1);
        tick();
        chk("bp_r1_rsp", {rsp1_valid, rsp0_valid, rsp_c}, {2'b10, 16'h000B});
        tick();
        exp_ops += 2;
        chk("bp_ops", ops_done, exp_ops);

        // reset while an operation is in ISSUE
        req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0001; req0_op = 4'h0;
        tick();
        req0_valid = 1'b0;
        chk("mr_in_issue", busy, 1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("mr_outputs", {busy, rsp1_valid, rsp0_valid, rsp_cout, rsp_c, alu_a, alu_b, alu_op}, 0);
        chk("mr_ops", ops_done, 0);
        tick();
        chk("mr_no_rsp", {busy, rsp1_valid, rsp0_valid}, 0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("mr_tie_grant0", {req1_ready, req0_ready}, 2'b01);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        chk("mr_tie_rsp", {rsp1_valid, rsp0_valid}, 2'b01);
        tick();

        // counter wrap on the 2-bit instance
        chk("wrap_start", w_ops, 0);
        w_v0 = 1'b1;
        repeat (9) tick();
        chk("wrap_three", w_ops, 3);
        repeat (3) tick();
        w_v0 = 1'b0;
        chk("wrap_zero", w_ops, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one combinational 16-bit ALU between two requesters.
- Sits between two client blocks and a single ALU instance (operands A/B, 4-bit opcode, result C, overflow flag Cout).
- Handles per-requester valid/ready request and response handshakes.
- Registers the operands, issues them to the ALU, captures the result, and returns it to the requester that was granted.

Parameters:
- WIDTH, 16, operand/result width; must match the ALU.
- OP_W, 4, opcode width; must match the ALU.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 request accepted this cycle.
- req0_a, req0_b  input  WIDTH  requester 0 operands.
- req0_op  input  OP_W  requester 0 ALU opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_op  (same as requester 0)  requester 1.
- rsp0_valid  output  1  result available for requester 0.
- rsp0_ready  input  1  requester 0 consumes the result.
- rsp1_valid  output  1  result available for requester 1.
- rsp1_ready  input  1  requester 1 consumes the result.
- rsp_c  output  WIDTH  result value; shared bus, meaningful only while rsp0_valid or rsp1_valid is high.
- rsp_cout  output  1  ALU overflow flag for that result.
- alu_a, alu_b  output  WIDTH  operands to the ALU; registered.
- alu_op  output  OP_W  opcode to the ALU; registered.
- alu_c  input  WIDTH  ALU result.
- alu_cout  input  1  ALU overflow flag.
- busy  output  1  high in any state other than IDLE.
- ops_done  output  CNT_W  count of completed responses; wraps to 0.

Behaviour:
- Reset (reset_n low at a clock edge):
  - State goes to IDLE.
  - alu_a, alu_b, alu_op, rsp_c, rsp_cout, ops_done all go to 0.
  - rsp0_valid and rsp1_valid go to 0.
  - last_grant goes to 1, so requester 0 wins the first tie.
  - An operation in flight is discarded; no response is produced for it.
- States: IDLE, ISSUE, RESP.
- IDLE, arbitration:
  - req0_ready and req1_ready are combinational and high only in IDLE.
  - Only one valid: that requester is granted.
  - Both valid: the requester that is not last_grant is granted.
  - Neither valid: both ready signals stay 0.
  - At most one ready is high in any cycle. ready may depend on valid; valid must not depend on ready.
- Handshake (valid & ready at edge N):
  - The winner's a, b and op are latched into alu_a, alu_b and alu_op.
  - The grant ID and last_grant are updated.
  - State goes to ISSUE.
- ISSUE (cycle N+1):
  - The ALU evaluates combinationally.
  - At the end of the cycle, alu_c and alu_cout are captured into rsp_c and rsp_cout.
  - State goes to RESP.
- RESP (from cycle N+2):
  - rspX_valid is high for the granted ID only.
  - rsp_c and rsp_cout hold steady while valid is high.
  - When rspX_ready is high at an edge: valid drops, ops_done increments (wrapping at 2^CNT_W), state returns to IDLE.
  - If ready stays low, the block holds in RESP indefinitely.
  - The other requester is blocked while the block is in RESP.
- Timing:
  - Minimum latency from request acceptance to rsp_valid is 2 cycles.
  - Peak throughput is one operation per 3 cycles.
  - rsp_ready sampled high on the first RESP cycle means IDLE on the next cycle.
- alu_a, alu_b and alu_op keep their last value after completion; they are not cleared.
- Requests whose valid drops before ready is asserted are simply not serviced.
- Opcodes are passed through unchanged; the arbiter does not interpret them.

Test Plan:
- Reset, then req0 alone: a=0x0003, b=0x0004, op=0000 with rsp0_ready=1.
  - Expect req0_ready in the same cycle.
  - Expect rsp0_valid 2 cycles later with rsp_c=0x0007, rsp_cout=0.
  - Expect ops_done=1.
- Overflow pass-through: req1 a=0x7FFF, b=0x0001, op=0000.
  - Expect rsp1_valid with rsp_c=0x8000, rsp_cout=1.
  - Expect rsp0_valid to stay 0.
- Tie: both requesters valid continuously after reset. req0 uses op=0010 (AND) on 0xF0F0/0xFF00; req1 uses op=0110 (XOR) on the same operands.
  - Expect grants in the order 0, 1, 0, 1.
  - Expect results alternating 0xF000 and 0x0FF0.
  - Expect one response every 3 cycles.
- Backpressure: hold rsp0_ready=0 for 5 cycles while req1_valid is high.
  - Expect rsp_c stable and rsp0_valid high throughout.
  - Expect req1_ready=0 throughout.
  - Release rsp0_ready: expect IDLE next, then req1 granted.
- Reset mid-operation: assert reset_n=0 during ISSUE.
  - Expect no rspX_valid afterward.
  - Expect all outputs 0 and busy=0.
  - Expect the next tie to grant requester 0.
- Counter wrap: preload by issuing 2^CNT_W operations, or run with CNT_W=2 and 4 operations.
  - Expect ops_done to wrap to 0.
